deck_shuffler: RTL and testbench
================================

Name: deck_shuffler

Overview:
Parametrised successor to the single-cycle card shuffler. It holds an N_CARDS deck in an internal register array and shuffles it with sequential Fisher-Yates, one swap per accepted draw, using a seedable free-running Galois LFSR with rejection sampling, so the index distribution is unbiased. It adds a deal port that hands out cards in order with an empty flag, and sits between the game FSM and the hand/score logic.

Parameters:
N_CARDS, 52, deck size; legal range 2..256
CARD_W, 6, card code width; must be >= clog2(N_CARDS)
LFSR_W, 16, LFSR width; must be >= clog2(N_CARDS)
LFSR_TAPS, 16'hB400, Galois feedback mask; default is maximal-length for 16 bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
seed_valid  in  1  load seed into LFSR this cycle
seed  in  LFSR_W  seed value
start  in  1  request shuffle; honoured only in READY
busy  out  1  high in INIT and SHUFFLE
ready  out  1  high in READY
done  out  1  one-cycle pulse when a shuffle completes
deal_req  in  1  request next card; honoured only in READY
deal_valid  out  1  registered; high the cycle after an accepted deal_req
deal_card  out  CARD_W  dealt card code; valid while deal_valid is high
cards_left  out  clog2(N_CARDS+1)  undealt cards remaining
deck_empty  out  1  cards_left==0

Behaviour:
- Reset (rst=1 at a clk edge): state=INIT, k=0, i=0, ptr=0, lfsr=1, and all outputs 0 except busy=1. Reset mid-operation discards the current deck and restarts INIT.
- INIT: writes deck[k]=k and increments k each cycle. After deck[N_CARDS-1] is written, the block enters READY with ptr=0 and cards_left=N_CARDS. INIT lasts exactly N_CARDS cycles.
- LFSR free-runs every cycle in every state: next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - seed_valid in any state except during rst overrides the step and loads seed; a seed of 0 loads 1.
  - seed_valid and start in the same cycle: the seed loads first, and the shuffle starts next cycle using the seeded value.
- READY + start: enters SHUFFLE with i=N_CARDS-1. ptr and cards_left are frozen, then restored to 0 and N_CARDS at done. The shuffle permutes the current deck contents; it does not reset to identity.
- SHUFFLE, per cycle:
  - m = clog2(i+1); cand = lfsr[m-1:0], zero-extended.
  - If cand <= i: swap deck[i] and deck[cand] (cand==i is a no-op), then decrement i.
  - Else reject: no write, i unchanged.
  - When a swap occurs with i==1, the next state is READY, done pulses for 1 cycle, ptr=0, and cards_left=N_CARDS.
  - Minimum duration is N_CARDS-1 cycles; rejections add cycles.
- start, deal_req while busy: ignored, no queuing.
- READY + deal_req with cards_left>0: next cycle deal_valid=1, deal_card=deck[ptr]; ptr increments and cards_left decrements.
  - Back-to-back requests give one card per cycle.
- deal_req when deck_empty: ignored; deal_valid stays 0 and the request has no side effect.
- deal_req and start in the same READY cycle: start wins and the deal is dropped.
- deal_valid, deal_card: deal_card holds its last value when deal_valid=0. Both are cleared by rst.
- ready=1 exactly when state==READY; busy=!ready.

Test Plan:
- Reset then release; count cycles -> busy=1 for exactly 52 cycles, then ready=1 with cards_left=52.
- No shuffle; 52 consecutive deal_req -> deal_card = 0,1,...,51 on successive deal_valid cycles. A 53rd deal_req -> deal_valid stays 0, deck_empty=1.
- seed_valid with seed=16'h0000 in READY -> lfsr=16'h0001 next cycle; the LFSR sequence then matches the reference model for taps B400.
- seed=16'hACE1 then start next cycle; deal 52 -> cards are a permutation of 0..51 and match the golden-model sequence. done pulses once; busy lasts >= 51 cycles.
- Repeat the previous scenario after rst with identical cycle timing -> identical card sequence. start pulses during busy -> no effect.
- Assert rst mid-shuffle at i=20 -> INIT restarts. After 52 cycles, dealing yields the identity order 0..51.

Source files
------------

// File: rtl/deck_shuffler.sv
// Card deck held in a register array, shuffled in place by sequential Fisher-Yates
// (one accepted draw per cycle from a free-running Galois LFSR) and dealt in order.
module deck_shuffler #(
    parameter int unsigned       N_CARDS   = 52,
    parameter int unsigned       CARD_W    = 6,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           seed_valid,
    input  logic [LFSR_W-1:0]              seed,
    input  logic                           start,
    output logic                           busy,
    output logic                           ready,
    output logic                           done,
    input  logic                           deal_req,
    output logic                           deal_valid,
    output logic [CARD_W-1:0]              deal_card,
    output logic [$clog2(N_CARDS+1)-1:0]   cards_left,
    output logic                           deck_empty
);
    localparam int unsigned    IW   = $clog2(N_CARDS);
    localparam int unsigned    CW   = $clog2(N_CARDS + 1);
    localparam logic [IW-1:0]  LAST = IW'(N_CARDS - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_READY,
        S_SHUFFLE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       k_q, k_d;
    logic [IW-1:0]       i_q, i_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cl_q, cl_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                done_q, done_d;
    logic                dv_q, dv_d;
    logic [CARD_W-1:0]   dc_q, dc_d;
    logic [CARD_W-1:0]   deck_q [N_CARDS];
    logic [CARD_W-1:0]   deck_d [N_CARDS];

    logic [LFSR_W-1:0]   lfsr_step;
    logic [IW-1:0]       mask;
    logic [IW-1:0]       cand;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

    // mask keeps the low clog2(i+1) bits: every bit up to the MSB of i
    always_comb begin
        mask = '0;
        for (int unsigned b = 0; b < IW; b++) begin
            mask[b] = |(i_q >> b);
        end
        cand = lfsr_q[IW-1:0] & mask;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        ptr_d   = ptr_q;
        cl_d    = cl_q;
        done_d  = 1'b0;
        dv_d    = 1'b0;
        dc_d    = dc_q;
        deck_d  = deck_q;
        lfsr_d  = seed_valid ? ((seed == '0) ? LFSR_W'(1) : seed) : lfsr_step;

        case (state_q)
            S_INIT: begin
                deck_d[k_q] = CARD_W'(k_q);
                if (k_q == LAST) begin
                    state_d = S_READY;
                    ptr_d   = '0;
                    cl_d    = CW'(N_CARDS);
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_SHUFFLE;
                    i_d     = LAST;
                end else if (deal_req && (cl_q != '0)) begin
                    dv_d  = 1'b1;
                    dc_d  = deck_q[ptr_q[IW-1:0]];
                    ptr_d = ptr_q + CW'(1);
                    cl_d  = cl_q - CW'(1);
                end
            end
            S_SHUFFLE: begin
                // out-of-range candidates are rejected; the next LFSR value is tried
                if (cand <= i_q) begin
                    deck_d[i_q]  = deck_q[cand];
                    deck_d[cand] = deck_q[i_q];
                    i_d          = i_q - IW'(1);
                    if (i_q == IW'(1)) begin
                        state_d = S_READY;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                        cl_d    = CW'(N_CARDS);
                    end
                end
            end
            default: begin
                state_d = S_INIT;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            k_q     <= '0;
            i_q     <= '0;
            ptr_q   <= '0;
            cl_q    <= '0;
            lfsr_q  <= LFSR_W'(1);
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            ptr_q   <= ptr_d;
            cl_q    <= cl_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
            dc_q    <= dc_d;
        end
    end

    // deck contents need no reset: INIT rewrites every entry
    always_ff @(posedge clk) begin
        deck_q <= deck_d;
    end

    assign ready      = (state_q == S_READY);
    assign busy       = ~ready;
    assign done       = done_q;
    assign deal_valid = dv_q;
    assign deal_card  = dc_q;
    assign cards_left = cl_q;
    assign deck_empty = (cl_q == '0);

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench for deck_shuffler: Fisher-Yates reference model with rejection
// sampling predicts dealt cards and shuffle length; a monitor pops and compares.
module tb_deck_shuffler;
    localparam int N = 52;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [15:0] seed = '0;
    logic        start = 1'b0;
    logic        deal_req = 1'b0;
    logic        busy, ready, done, deal_valid, deck_empty;
    logic [5:0]  deal_card;
    logic [5:0]  cards_left;

    deck_shuffler #(
        .N_CARDS   (N),
        .CARD_W    (6),
        .LFSR_W    (16),
        .LFSR_TAPS (16'hB400)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .start      (start),
        .busy       (busy),
        .ready      (ready),
        .done       (done),
        .deal_req   (deal_req),
        .deal_valid (deal_valid),
        .deal_card  (deal_card),
        .cards_left (cards_left),
        .deck_empty (deck_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int dealt[$];
    int first_seq[$];
    int last_card = 0;
    int m_lfsr = 1;
    int deck_m[N];
    int m_ptr = 0;
    int m_cl  = 0;

    function automatic int lstep(input int l);
        return (l >> 1) ^ (((l & 1) != 0) ? 32'hB400 : 32'h0);
    endfunction

    function automatic int bitlen(input int v);
        int m = 0;
        while ((1 << m) <= v) m++;
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LFSR as described: free-running, seed override, zero seed maps to 1
    always @(posedge clk) begin
        if (rst)             m_lfsr <= 1;
        else if (seed_valid) m_lfsr <= (seed == 16'h0) ? 1 : int'(seed);
        else                 m_lfsr <= lstep(m_lfsr);
    end

    always @(negedge clk) begin
        if (!rst && deal_valid) begin
            check("deal_valid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                check("deal_card", deal_card, e);
                dealt.push_back(int'(deal_card));
                last_card = int'(deal_card);
            end
        end
    end

    task automatic do_reset();
        int cnt;
        rst = 1'b1; start = 1'b0; deal_req = 1'b0; seed_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_deal_valid", deal_valid, 0);
        check("rst_cards_left", cards_left, 0);
        for (int j = 0; j < N; j++) deck_m[j] = j;
        m_ptr = 0; m_cl = 0; last_card = 0;
        exp_q.delete();
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("init_cycles", cnt, N);
        check("init_ready", ready, 1);
        check("init_cards_left", cards_left, N);
        check("init_deck_empty", deck_empty, 0);
        m_cl = N;
    endtask

    task automatic deal_cycles(input int n, input bit gaps);
        for (int c = 0; c < n; c++) begin
            bit r;
            r = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            deal_req = r;
            if (r && m_cl > 0) begin
                exp_q.push_back(deck_m[m_ptr]);
                m_ptr++;
                m_cl--;
            end
            @(negedge clk);
        end
        deal_req = 1'b0;
        repeat (2) @(negedge clk);
        check("deal_drained", exp_q.size(), 0);
        check("cards_left", cards_left, m_cl);
        check("deck_empty", deck_empty, int'(m_cl == 0));
        check("deal_card_hold", deal_card, last_card);
    endtask

    task automatic check_perm();
        int once = 0;
        for (int v = 0; v < N; v++) begin
            int hits = 0;
            foreach (dealt[j]) if (dealt[j] == v) hits++;
            if (hits == 1) once++;
        end
        check("dealt_is_permutation", once, N);
    endtask

    task automatic run_shuffle(input bit deal_too, input bit abort);
        int l, d, at20, cnt, dones;
        int tmp[N];
        start = 1'b1;
        deal_req = deal_too;
        @(negedge clk);
        start = 1'b0; deal_req = 1'b0; seed_valid = 1'b0;
        // first SHUFFLE cycle: m_lfsr is the value the first draw sees
        l = m_lfsr; d = 0; at20 = -1;
        tmp = deck_m;
        for (int i = N - 1; i >= 1; i--) begin
            int r, t;
            if (i == 20) at20 = d;
            do begin
                r = l % (1 << bitlen(i));
                l = lstep(l);
                d++;
            end while (r > i);
            t = tmp[i]; tmp[i] = tmp[r]; tmp[r] = t;
        end
        if (abort) begin
            repeat (at20) @(negedge clk);
            check("abort_still_busy", busy, 1);
            do_reset();
            return;
        end
        cnt = 0; dones = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            dones += int'(done);
            start = 1'($urandom_range(0, 1));
            deal_req = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0; deal_req = 1'b0;
        check("shuffle_cycles", cnt, d);
        check("done_in_busy", dones, 0);
        check("done_pulse", done, 1);
        check("shuffle_ready", ready, 1);
        check("shuffle_cards_left", cards_left, N);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_holds", ready, 1);
        deck_m = tmp; m_ptr = 0; m_cl = N;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        dealt.delete();
        deal_cycles(N, 1'b0);
        check_perm();
        deal_cycles(1, 1'b0);

        seed_valid = 1'b1; seed = 16'hACE1;
        @(negedge clk);
        seed_valid = 1'b0;
        run_shuffle(1'b0, 1'b0);
        dealt.delete();
        deal_cycles(N, 1'b0);
        check_perm();
        first_seq = dealt;

        do_reset();
        seed_valid = 1'b1; seed = 16'hACE1;
        @(negedge clk);
        seed_valid = 1'b0;
        run_shuffle(1'b0, 1'b0);
        dealt.delete();
        deal_cycles(N, 1'b0);
        begin
            int diffs = 0;
            foreach (first_seq[j]) if (j >= dealt.size() || dealt[j] != first_seq[j]) diffs++;
            check("repeat_sequence_diffs", diffs, 0);
        end

        // zero seed together with start and a colliding deal request
        seed_valid = 1'b1; seed = 16'h0000;
        run_shuffle(1'b1, 1'b0);
        deal_cycles(20, 1'b1);

        for (int it = 0; it < 3; it++) begin
            seed_valid = 1'b1; seed = 16'($urandom);
            @(negedge clk);
            seed_valid = 1'b0;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_shuffle(1'b0, 1'b0);
            dealt.delete();
            deal_cycles($urandom_range(10, 70), 1'b1);
        end

        seed_valid = 1'b1; seed = 16'h1234;
        @(negedge clk);
        seed_valid = 1'b0;
        run_shuffle(1'b0, 1'b1);
        dealt.delete();
        deal_cycles(N, 1'b0);
        check_perm();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
